seg_decode_monitor: RTL and testbench
=====================================

# seg_decode_monitor

Reads back the active-low seven-segment patterns driven onto the HEX display buses and recovers the displayed digits as BCD, with per-digit blank/invalid flags. Each digit is debounced: a pattern must be held for a programmable number of cycles before it commits. Every change of the committed display word is delivered on a valid/ready output port. The block sits beside the display drivers as a self-check and readback path for the microphone level display.

## Interface
- NUM_DIGITS, 4, number of seven-segment digits monitored (1..8)
- STABLE_CYCLES, 16, consecutive identical samples required before a digit pattern commits (≥2)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- segments_in  in  7*NUM_DIGITS  active-low patterns; digit i at bits [7i+6:7i]; bit 0 = segment a … bit 6 = segment g
- bcd_out  out  4*NUM_DIGITS  decoded digits; digit i at bits [4i+3:4i]
- blank_out  out  NUM_DIGITS  digit i pattern is all-off (7'b1111111)
- invalid_out  out  NUM_DIGITS  digit i pattern not in the decode table
- value_valid  out  1  output word pending
- value_ready  in  1  consumer accepts the word when value_valid is high
- overrun  out  1  sticky; a pending word was replaced before it was accepted

## Operation
- segments_in is registered once (sample_q) before any use.
- Per digit:
  - Keep a candidate pattern and a stability counter.
  - If the sample differs from the candidate: load the candidate and clear the counter.
  - If it matches: increment the counter, saturating.
- A digit commits when its pattern has been sampled on STABLE_CYCLES+1 consecutive edges and its decode differs from the committed value.
- Digits commit independently. Several digits may commit on the same edge.
- Decode table (pattern gfedcba → value):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9
  - 1111111→blank: bcd 0, blank=1
  - any other pattern → bcd 0, invalid=1
  - blank and invalid are never both set.
- Output register (bcd_out, blank_out, invalid_out) is loaded with the full committed word on any edge where at least one digit commits.
- value_valid:
  - Set on that edge.
  - Cleared on an edge with value_valid && value_ready and no commit.
- Commit while value_valid && !value_ready:
  - Newest word overwrites the output register; value_valid stays 1; overrun sets.
- Commit on the same edge as acceptance:
  - New word loads; value_valid stays 1; overrun unchanged.
- A pattern that returns to the committed value before or after debouncing produces no output update.
- value_ready is ignored while value_valid is low.

## Timing
- Reset values:
  - bcd_out = 0, blank_out = all ones, invalid_out = 0, value_valid = 0, overrun = 0.
  - Committed state = blank for every digit.
  - Candidates = 7'h7F with counters cleared.
  - An all-blank display after reset therefore produces no word.
- Latency: pattern stable at the pins from before edge E0 → word visible and value_valid high after edge E0+STABLE_CYCLES.
- Glitch filtering: any disturbance shorter than STABLE_CYCLES+1 samples never commits and restarts the count.
- Output register and value_valid are stable while value_valid && !value_ready, except for an overwriting commit.
- Reset asserted mid-debounce or with a word pending:
  - All state returns to reset values on that edge.
  - The pending word is discarded; overrun clears.

## Configuration
- SEG_DECODE_MONITOR_HEX_EN defined:
  - Hex glyphs also decode: 0001000→A, 0000011→b, 1000110→C, 0100001→d, 0000110→E, 0001110→F (values 10..15), invalid=0.
- Not defined:
  - These six patterns decode as invalid (bcd 0, invalid=1).
- Debounce and handshake behaviour is identical in both builds.

## Test plan
- Reset, segments_in all 1s for 40 cycles → value_valid stays 0; bcd_out=0; blank_out=4'hF.
- Digit0=0100100, digit1=0010000, digits2–3 blank, held with value_ready=1 → value_valid rises after edge E0+16 for exactly one cycle; bcd_out=16'h0092, blank_out=4'b1100.
- Digit0 glitches to 1111001 for 10 cycles, then returns to 0100100 → no new word.
- value_ready=0; commit 3 on digit0, then commit 7 → value_valid held, bcd_out digit0=7, overrun=1; raising value_ready clears value_valid next edge; overrun stays 1.
- Digit0=0001000:
  - with SEG_DECODE_MONITOR_HEX_EN → bcd digit0=4'hA, invalid=0
  - without → bcd 0, invalid_out[0]=1
- Reset pulse 5 cycles into debounce with a word pending → all outputs at reset values on the next edge; debounce restarts from zero.

Source files
------------

// File: rtl/seg_decode_monitor_if.sv
// Bus between the seven-segment readback monitor and its consumer.
// master: the monitor (samples segments, drives decoded word and handshake).
// slave : the consumer / display-driver side.
interface seg_decode_monitor_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [7*NUM_DIGITS-1:0] segments_in;
   logic [4*NUM_DIGITS-1:0] bcd_out;
   logic [NUM_DIGITS-1:0]   blank_out;
   logic [NUM_DIGITS-1:0]   invalid_out;
   logic                    value_valid;
   logic                    value_ready;
   logic                    overrun;

   modport master (
      input  segments_in,
      input  value_ready,
      output bcd_out,
      output blank_out,
      output invalid_out,
      output value_valid,
      output overrun
   );

   modport slave (
      output segments_in,
      output value_ready,
      input  bcd_out,
      input  blank_out,
      input  invalid_out,
      input  value_valid,
      input  overrun
   );
endinterface

// File: rtl/seg_decode_monitor.sv
// Seven-segment readback monitor: registers the active-low HEX patterns,
// debounces each digit independently, decodes committed patterns to BCD
// with blank/invalid flags and presents every change of the committed
// word on a valid/ready port with a sticky overrun flag.
// Optional build macro SEG_DECODE_MONITOR_HEX_EN: also decode A..F glyphs.
module seg_decode_monitor #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   seg_decode_monitor_if.master  bus
);

`ifdef SEG_DECODE_MONITOR_HEX_EN
   localparam logic HEX_EN = 1'b1;
`else
   localparam logic HEX_EN = 1'b0;
`endif

   // Counter only has to reach STABLE_CYCLES-1; it saturates there.
   localparam int unsigned   CW         = $clog2(STABLE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_SAT    = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_COMMIT = CW'(STABLE_CYCLES - 2);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [6:0]    PAT_BLANK  = 7'h7F;

   typedef struct packed {
      logic       invalid;
      logic       blank;
      logic [3:0] bcd;
   } digit_t;

   localparam digit_t DIGIT_BLANK   = '{invalid: 1'b0, blank: 1'b1, bcd: 4'd0};
   localparam digit_t DIGIT_INVALID = '{invalid: 1'b1, blank: 1'b0, bcd: 4'd0};

   function automatic digit_t glyph(input logic [3:0] v);
      glyph = '{invalid: 1'b0, blank: 1'b0, bcd: v};
   endfunction

   // Pattern bits are gfedcba, active low.
   function automatic digit_t decode_pattern(input logic [6:0] pat);
      digit_t d;
      d = DIGIT_INVALID;
      case (pat)
         7'b1000000: d = glyph(4'd0);
         7'b1111001: d = glyph(4'd1);
         7'b0100100: d = glyph(4'd2);
         7'b0110000: d = glyph(4'd3);
         7'b0011001: d = glyph(4'd4);
         7'b0010010: d = glyph(4'd5);
         7'b0000010: d = glyph(4'd6);
         7'b1111000: d = glyph(4'd7);
         7'b0000000: d = glyph(4'd8);
         7'b0010000: d = glyph(4'd9);
         7'b0001000: d = HEX_EN ? glyph(4'hA) : DIGIT_INVALID;
         7'b0000011: d = HEX_EN ? glyph(4'hB) : DIGIT_INVALID;
         7'b1000110: d = HEX_EN ? glyph(4'hC) : DIGIT_INVALID;
         7'b0100001: d = HEX_EN ? glyph(4'hD) : DIGIT_INVALID;
         7'b0000110: d = HEX_EN ? glyph(4'hE) : DIGIT_INVALID;
         7'b0001110: d = HEX_EN ? glyph(4'hF) : DIGIT_INVALID;
         PAT_BLANK:  d = DIGIT_BLANK;
         default:    d = DIGIT_INVALID;
      endcase
      return d;
   endfunction

   logic [7*NUM_DIGITS-1:0] sample_q;

   logic [6:0]    cand_q [NUM_DIGITS];
   logic [6:0]    cand_d [NUM_DIGITS];
   logic [CW-1:0] cnt_q  [NUM_DIGITS];
   logic [CW-1:0] cnt_d  [NUM_DIGITS];
   digit_t        com_q  [NUM_DIGITS];
   digit_t        com_d  [NUM_DIGITS];
   digit_t        cand_dec [NUM_DIGITS];

   logic [NUM_DIGITS-1:0] commit;
   logic [NUM_DIGITS-1:0] match;
   logic                  any_commit;

   logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d;
   logic [NUM_DIGITS-1:0]   invalid_q, invalid_d;
   logic                    valid_q, valid_d;
   logic                    overrun_q, overrun_d;

   // Input register: the pins are only ever used through this sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_q <= '1;
      end else begin
         sample_q <= bus.segments_in;
      end
   end

   // Per-digit debounce and commit decision.
   // Candidate is reloaded one edge after the sample changes, so a count of
   // STABLE_CYCLES-2 on a matching sample means STABLE_CYCLES+1 sampling edges.
   always_comb begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         cand_d[i]   = cand_q[i];
         cnt_d[i]    = cnt_q[i];
         com_d[i]    = com_q[i];
         cand_dec[i] = decode_pattern(cand_q[i]);
         match[i]    = (sample_q[7*i +: 7] == cand_q[i]);
         commit[i]   = match[i] && (cnt_q[i] >= CNT_COMMIT) &&
                       (cand_dec[i] != com_q[i]);
         if (!match[i]) begin
            cand_d[i] = sample_q[7*i +: 7];
            cnt_d[i]  = '0;
         end else if (cnt_q[i] != CNT_SAT) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
         if (commit[i]) begin
            com_d[i] = cand_dec[i];
         end
      end
   end

   // Debounce and committed-value state.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            cand_q[i] <= PAT_BLANK;
            cnt_q[i]  <= '0;
            com_q[i]  <= DIGIT_BLANK;
         end
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         com_q  <= com_d;
      end
   end

   // Output word, valid/ready handshake and sticky overrun.
   always_comb begin
      any_commit = |commit;
      bcd_d      = bcd_q;
      blank_d    = blank_q;
      invalid_d  = invalid_q;
      valid_d    = valid_q;
      overrun_d  = overrun_q;
      if (any_commit) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            bcd_d[4*i +: 4] = com_d[i].bcd;
            blank_d[i]      = com_d[i].blank;
            invalid_d[i]    = com_d[i].invalid;
         end
         valid_d = 1'b1;
         if (valid_q && !bus.value_ready) begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && bus.value_ready) begin
         valid_d = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         bcd_q     <= '0;
         blank_q   <= '1;
         invalid_q <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         bcd_q     <= bcd_d;
         blank_q   <= blank_d;
         invalid_q <= invalid_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.bcd_out     = bcd_q;
   assign bus.blank_out   = blank_q;
   assign bus.invalid_out = invalid_q;
   assign bus.value_valid = valid_q;
   assign bus.overrun     = overrun_q;

   // A digit is never flagged both blank and invalid.
   a_blank_invalid_excl: assert property (
      @(posedge clk) disable iff (reset) (blank_q & invalid_q) == '0);

   // Overrun is sticky until reset.
   a_overrun_sticky: assert property (
      @(posedge clk) disable iff (reset) overrun_q |=> overrun_q);

   // A pending, unaccepted word is held unless a newer word overwrites it.
   a_valid_hold: assert property (
      @(posedge clk) disable iff (reset)
      (valid_q && !bus.value_ready && !any_commit) |=> valid_q);

endmodule

// File: tb/tb_seg_decode_monitor.sv
// Self-checking bench for seg_decode_monitor: directed sequences, a decode
// table sweep and randomized stimulus against a run-length reference model.
module tb_seg_decode_monitor;
   localparam int unsigned ND = 4;
   localparam int unsigned SC = 16;

`ifdef SEG_DECODE_MONITOR_HEX_EN
   localparam bit TB_HEX = 1'b1;
`else
   localparam bit TB_HEX = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   seg_decode_monitor_if #(.NUM_DIGITS(ND)) bus ();

   seg_decode_monitor #(
      .NUM_DIGITS    (ND),
      .STABLE_CYCLES (SC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // glyph_pat[v] is the active-low gfedcba pattern of hex value v.
   logic [6:0] glyph_pat [16];

   // Reference model: per digit the latest captured pattern and how many
   // consecutive edges captured it; committed value; output word.
   logic [5:0]      m_com  [ND];
   logic [6:0]      m_last [ND];
   int              m_run  [ND];
   logic [4*ND-1:0] m_bcd;
   logic [ND-1:0]   m_blank, m_inv;
   logic            m_valid, m_ovr;

   // {invalid, blank, value[3:0]}
   function automatic logic [5:0] ref_decode(input logic [6:0] pat);
      int top;
      top = TB_HEX ? 15 : 9;
      if (pat == 7'h7F) return 6'b01_0000;
      for (int v = 0; v <= top; v++) begin
         if (glyph_pat[v] == pat) return {2'b00, 4'(v)};
      end
      return 6'b10_0000;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         m_com[d]  = 6'b01_0000;
         m_last[d] = 7'h7F;
         m_run[d]  = 2;
      end
      m_bcd   = '0;
      m_blank = '1;
      m_inv   = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_edge(input logic [7*ND-1:0] seg, input logic rdy, input logic rst);
      bit         any;
      logic [5:0] g;
      logic [6:0] p;
      if (rst) begin
         model_reset();
         return;
      end
      any = 1'b0;
      for (int d = 0; d < ND; d++) begin
         g = ref_decode(m_last[d]);
         if (m_run[d] >= SC && g != m_com[d]) begin
            m_com[d] = g;
            any = 1'b1;
         end
      end
      for (int d = 0; d < ND; d++) begin
         p = seg[7*d +: 7];
         if (p == m_last[d]) begin
            if (m_run[d] < 1000) m_run[d]++;
         end else begin
            m_last[d] = p;
            m_run[d]  = 1;
         end
      end
      if (any) begin
         for (int d = 0; d < ND; d++) begin
            m_bcd[4*d +: 4] = m_com[d][3:0];
            m_blank[d]      = m_com[d][4];
            m_inv[d]        = m_com[d][5];
         end
         if (m_valid && !rdy) m_ovr = 1'b1;
         m_valid = 1'b1;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
   endtask

   function automatic logic [25:0] dut_word();
      return {bus.value_valid, bus.overrun, bus.invalid_out, bus.blank_out, bus.bcd_out};
   endfunction

   function automatic logic [25:0] model_word();
      return {m_valid, m_ovr, m_inv, m_blank, m_bcd};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // One clock edge: advance the model with the inputs seen at that edge,
   // then compare the whole output word just after the edge.
   task automatic tick();
      model_edge(bus.segments_in, bus.value_ready, reset);
      @(posedge clk);
      #1;
      check("model_word", 64'(dut_word()), 64'(model_word()));
   endtask

   task automatic set_digit(input int d, input logic [6:0] p);
      logic [7*ND-1:0] s;
      s = bus.segments_in;
      s[7*d +: 7] = p;
      bus.segments_in = s;
   endtask

   typedef struct {
      logic [6:0] pat;
      logic [3:0] val;
      logic       blk;
      logic       inv;
   } vec_t;

   localparam logic [25:0] RESET_WORD = {1'b0, 1'b0, 4'h0, 4'hF, 16'h0000};

   initial begin
      vec_t            tbl [18];
      bit              seen;
      int              hold [ND];
      logic [7*ND-1:0] sv;
      int              r;

      glyph_pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

      for (int v = 0; v < 10; v++) tbl[v] = '{glyph_pat[v], 4'(v), 1'b0, 1'b0};
      tbl[10] = '{7'h7F, 4'd0, 1'b1, 1'b0};
      for (int v = 10; v < 16; v++) begin
         if (TB_HEX) tbl[v+1] = '{glyph_pat[v], 4'(v), 1'b0, 1'b0};
         else        tbl[v+1] = '{glyph_pat[v], 4'd0, 1'b0, 1'b1};
      end
      tbl[16] = '{7'b1010101, 4'd0, 1'b0, 1'b1};
      tbl[17] = '{7'b0110000, 4'd3, 1'b0, 1'b0};

      reset = 1'b1;
      bus.segments_in = '1;
      bus.value_ready = 1'b0;
      model_reset();
      tick();
      tick();
      check("reset_state", 64'(dut_word()), 64'(RESET_WORD));
      reset = 1'b0;

      // All-blank display never produces a word.
      seen = 1'b0;
      repeat (40) begin
         tick();
         seen |= bus.value_valid;
      end
      check("blank_idle_valid", 64'(seen), 64'(0));
      check("blank_idle_word", 64'(dut_word()), 64'(RESET_WORD));

      // Latency: stable from before E0, valid after E0+SC for one cycle.
      bus.value_ready = 1'b1;
      set_digit(0, 7'b0100100);
      set_digit(1, 7'b0010000);
      repeat (SC) tick();
      check("latency_early", 64'(bus.value_valid), 64'(0));
      tick();
      check("latency_word", 64'({bus.value_valid, bus.bcd_out, bus.blank_out}),
            64'({1'b1, 16'h0092, 4'b1100}));
      tick();
      check("valid_one_cycle", 64'(bus.value_valid), 64'(0));

      // Glitch back to the committed value: no word.
      set_digit(0, 7'b1111001);
      repeat (10) tick();
      set_digit(0, 7'b0100100);
      seen = 1'b0;
      repeat (SC + 5) begin
         tick();
         seen |= bus.value_valid;
      end
      check("glitch_no_word", 64'({seen, bus.bcd_out}), 64'({1'b0, 16'h0092}));

      // Overwrite of a pending word sets overrun; acceptance keeps it.
      bus.value_ready = 1'b0;
      set_digit(0, 7'b0110000);
      repeat (SC + 2) tick();
      check("pending_3", 64'({bus.value_valid, bus.bcd_out[3:0]}), 64'({1'b1, 4'd3}));
      set_digit(0, 7'b1111000);
      repeat (SC + 2) tick();
      check("overwrite_7", 64'({bus.value_valid, bus.overrun, bus.bcd_out[3:0]}),
            64'({1'b1, 1'b1, 4'd7}));
      bus.value_ready = 1'b1;
      tick();
      check("accept_clears", 64'({bus.value_valid, bus.overrun}), 64'({1'b0, 1'b1}));

      // Decode table sweep on digit 0.
      for (int k = 0; k < 18; k++) begin
         set_digit(0, tbl[k].pat);
         repeat (SC + 2) tick();
         check($sformatf("decode_%0d", k),
               64'({bus.bcd_out[3:0], bus.blank_out[0], bus.invalid_out[0]}),
               64'({tbl[k].val, tbl[k].blk, tbl[k].inv}));
      end

      // Reset mid-debounce with a word pending, then debounce restarts.
      bus.value_ready = 1'b0;
      set_digit(1, 7'b1111001);
      repeat (SC + 2) tick();
      check("pending_before_reset", 64'(bus.value_valid), 64'(1));
      set_digit(1, 7'b0000010);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      check("reset_mid", 64'(dut_word()), 64'(RESET_WORD));
      reset = 1'b0;
      repeat (SC) tick();
      check("restart_early", 64'(bus.value_valid), 64'(0));
      tick();
      check("restart_commit", 64'({bus.value_valid, bus.bcd_out, bus.blank_out, bus.invalid_out}),
            64'({1'b1, 16'h0063, 4'b1100, 4'b0000}));

      // Randomized run against the model.
      for (int d = 0; d < ND; d++) hold[d] = 0;
      repeat (3000) begin
         sv = bus.segments_in;
         for (int d = 0; d < ND; d++) begin
            if (hold[d] == 0) begin
               r = int'($urandom_range(0, 19));
               if (r < 16)       sv[7*d +: 7] = glyph_pat[r];
               else if (r == 16) sv[7*d +: 7] = 7'h7F;
               else              sv[7*d +: 7] = 7'($urandom);
               hold[d] = int'($urandom_range(1, SC + 8));
            end
            hold[d]--;
         end
         bus.segments_in = sv;
         bus.value_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
